time_set_ctrl: RTL and testbench
================================

# time_set_ctrl

Button-driven time-setting controller that sits directly upstream of the 12-hour timekeeping counter. It debounces two raw push-buttons and runs a RUN / SET_HR / SET_MIN state machine. It presents edited BCD hour and minute digits plus a one-cycle `load` strobe to the counter. It also provides a `run_en` hold and per-digit blink blanking for the 7-segment display path.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a button level (10 ms at 100 MHz).
- `BLINK_CYCLES`, default 25_000_000: half-period of the edit-digit blink (2 Hz toggle).
- `clk` in 1: 100 MHz system clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low. Clock is `clk`; reset is asynchronous active-low.
- `btn_mode` in 1: raw, asynchronous, bouncy mode button.
- `btn_up` in 1: raw, asynchronous, bouncy increment button.
- `cur_bcd0`..`cur_bcd3` in 4 each: live time from the counter (min ones, min tens, hr ones, hr tens).
- `set_bcd0`..`set_bcd3` out 4 each: edited time, registered, same digit order.
- `load` out 1: one-cycle strobe; downstream counter loads `set_bcd*` and clears its seconds count.
- `run_en` out 1: high means the counter advances; low means it holds.
- `blank_n` out 4: per-digit enable, bit i pairs with digit i; 0 means blank that digit.

## Operation
- Reset values:
  - state RUN;
  - `set_bcd3..0` = 1,2,0,0 (12:00);
  - `load` 0, `run_en` 1, `blank_n` 4'b1111;
  - synchronizers, debounced levels and all counters 0.
- Each button passes a 2-FF synchronizer, then a debouncer:
  - the counter restarts whenever the synchronized level differs from the candidate level;
  - the debounced level updates only after DEBOUNCE_CYCLES consecutive equal samples.
- A 0->1 transition of the debounced level produces a one-cycle press pulse (`p_mode`, `p_up`).
- FSM states and transitions:
  - RUN, on `p_mode`: capture `cur_bcd*` into `set_bcd*`, go to SET_HR. If the captured hour is outside 1..12, or min tens >5, or any digit >9, load 12:00 instead.
  - SET_HR, on `p_up`: hour increments 1->2 ... 9->10, 10->11, 11->12, 12->1. Hour tens is only ever 0 or 1.
  - SET_HR, on `p_mode`: go to SET_MIN.
  - SET_MIN, on `p_up`: minutes increment 00..59; 59 wraps to 00 with no carry into the hour.
  - SET_MIN, on `p_mode`: go to RUN and assert `load` for exactly that transition cycle.
  - `p_up` in RUN is ignored.
- Simultaneous `p_mode` and `p_up` in the same cycle: mode wins, the increment is discarded.
- `run_en` is 0 in SET_HR and SET_MIN, and 1 in RUN.
- Blink:
  - the phase counter toggles a blink bit every BLINK_CYCLES;
  - it restarts with the bit in the visible phase on every state entry and every accepted `p_up`;
  - in SET_HR, `blank_n[3:2]` follow the blink bit and `blank_n[1:0]`=11;
  - in SET_MIN, `blank_n[1:0]` follow the blink bit and `blank_n[3:2]`=11;
  - in RUN, `blank_n`=1111.
- Reset asserted mid-edit abandons the edit: no `load`, outputs return to reset values immediately (asynchronous).

## Timing
- Button to press pulse: 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 edge-detect cycle after the raw level settles.
- State, `set_bcd*`, `run_en`, `blank_n` and `load` are all registered and update on the cycle after the press pulse.
- `load` is high one cycle, coincident with the RUN state register and `run_en` = 1. `set_bcd*` are stable in that cycle and remain stable afterwards.
- `run_en` falls in the same cycle `set_bcd*` capture the live time, so the counter holds at the captured value.
- Glitches shorter than DEBOUNCE_CYCLES never produce a press.
- A held button produces one press only; it must be released (debounced 0) before the next press.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, BLINK_CYCLES=8.
- Reset: `rst_n`=0 mid-run -> `set_bcd`=1,2,0,0, `load`=0, `run_en`=1, `blank_n`=1111 with no clock edge required.
- Bounce: `btn_mode` toggling every 2 cycles for 20 cycles, then held high -> exactly one `p_mode`, 7 cycles after the final rise. State RUN->SET_HR, `run_en`=0.
- Hour wrap: capture 11:45, then 2x `btn_up` in SET_HR -> 12:45 then 01:45; `set_bcd3`=0, `set_bcd2`=1.
- Minute wrap: SET_MIN at 12:58, 2x `btn_up` -> 12:59 then 12:00; hour unchanged.
- Commit: mode press in SET_MIN at 03:27 -> single-cycle `load` with `set_bcd`=0,3,2,7 (tens-hr..ones-min); `run_en`=1 that cycle; `blank_n`=1111.
- Simultaneous presses and invalid capture:
  - mode and up pulses in the same cycle in SET_HR -> SET_MIN, hour unchanged;
  - capture with `cur_bcd`=1,3,6,0 -> `set_bcd`=12:00.

Source files
------------

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - button-driven RUN/SET_HR/SET_MIN time-setting controller
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic [3:0] cur_bcd0,
    input  logic [3:0] cur_bcd1,
    input  logic [3:0] cur_bcd2,
    input  logic [3:0] cur_bcd3,
    output logic [3:0] set_bcd0,
    output logic [3:0] set_bcd1,
    output logic [3:0] set_bcd2,
    output logic [3:0] set_bcd3,
    output logic       load,
    output logic       run_en,
    output logic [3:0] blank_n
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES);
    localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [15:0]   TIME_RST = 16'h1200;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_SET_HR  = 2'd1,
        S_SET_MIN = 2'd2
    } state_e;

    // bit 0 = mode button, bit 1 = up button
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    cand_q;
    logic [1:0]    deb_q;
    logic [1:0]    deb_prev_q;
    logic [1:0]    press_q;
    logic [DW-1:0] db_cnt_q [2];

    logic p_mode;
    logic p_up;
    logic up_ok;

    state_e        state_q, state_d;
    logic [15:0]   time_q, time_d;
    logic          load_q, load_d;
    logic          run_en_q, run_en_d;
    logic [3:0]    blank_n_q, blank_n_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic [15:0]   cur_time;

    assign btn_raw  = {btn_up, btn_mode};
    assign cur_time = {cur_bcd3, cur_bcd2, cur_bcd1, cur_bcd0};
    assign p_mode   = press_q[0];
    assign p_up     = press_q[1];
    // mode wins a tie; increments only count while editing
    assign up_ok    = p_up & ~p_mode & (state_q != S_RUN);

    function automatic logic [7:0] hr_inc(input logic [7:0] hr);
        if (hr == 8'h12)
            return 8'h01;
        else if (hr[3:0] == 4'd9)
            return 8'h10;
        else
            return {hr[7:4], hr[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] min_inc(input logic [7:0] mn);
        if (mn == 8'h59)
            return 8'h00;
        else if (mn[3:0] == 4'd9)
            return {mn[7:4] + 4'd1, 4'd0};
        else
            return {mn[7:4], mn[3:0] + 4'd1};
    endfunction

    function automatic logic time_valid(input logic [15:0] t);
        logic hr_ok;
        hr_ok = ((t[15:12] == 4'd0) && (t[11:8] >= 4'd1) && (t[11:8] <= 4'd9)) ||
                ((t[15:12] == 4'd1) && (t[11:8] <= 4'd2));
        return hr_ok && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    endfunction

    // synchronize, debounce and edge-detect both buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            cand_q     <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            press_q    <= '0;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            press_q    <= deb_q & ~deb_prev_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != cand_q[i]) begin
                    // level moved: this sample is the first of a new run
                    cand_q[i]   <= sync2_q[i];
                    db_cnt_q[i] <= DW'(1);
                end else begin
                    if (db_cnt_q[i] < DB_MAX) db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
                    if (db_cnt_q[i] >= DB_LAST) deb_q[i] <= cand_q[i];
                end
            end
        end
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            time_q      <= TIME_RST;
            load_q      <= 1'b0;
            run_en_q    <= 1'b1;
            blank_n_q   <= 4'b1111;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            load_q      <= load_d;
            run_en_q    <= run_en_d;
            blank_n_q   <= blank_n_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // next state: the mode press steps RUN -> SET_HR -> SET_MIN -> RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:     if (p_mode) state_d = S_SET_HR;
            S_SET_HR:  if (p_mode) state_d = S_SET_MIN;
            S_SET_MIN: if (p_mode) state_d = S_RUN;
            default:   state_d = S_RUN;
        endcase
    end

    // output next-values: edited time, load strobe, run hold, blink blanking
    always_comb begin
        time_d      = time_q;
        load_d      = 1'b0;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        blank_n_d   = 4'b1111;

        case (state_q)
            S_RUN: begin
                if (p_mode) time_d = time_valid(cur_time) ? cur_time : TIME_RST;
            end
            S_SET_HR: begin
                if (up_ok) time_d[15:8] = hr_inc(time_q[15:8]);
            end
            S_SET_MIN: begin
                if (p_mode)     load_d = 1'b1;
                else if (up_ok) time_d[7:0] = min_inc(time_q[7:0]);
            end
            default: ;
        endcase

        // restart in the visible phase so the edited digit shows right away
        if ((state_d != state_q) || up_ok) begin
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (blink_cnt_q == BL_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end

        run_en_d = (state_d == S_RUN);
        case (state_d)
            S_SET_HR:  blank_n_d = {blink_d, blink_d, 2'b11};
            S_SET_MIN: blank_n_d = {2'b11, blink_d, blink_d};
            default:   blank_n_d = 4'b1111;
        endcase
    end

    assign set_bcd3 = time_q[15:12];
    assign set_bcd2 = time_q[11:8];
    assign set_bcd1 = time_q[7:4];
    assign set_bcd0 = time_q[3:0];
    assign load     = load_q;
    assign run_en   = run_en_q;
    assign blank_n  = blank_n_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed-vector bench for time_set_ctrl
module tb_time_set_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_mode;
    logic       btn_up;
    logic [3:0] cur_bcd0, cur_bcd1, cur_bcd2, cur_bcd3;
    logic [3:0] set_bcd0, set_bcd1, set_bcd2, set_bcd3;
    logic       load;
    logic       run_en;
    logic [3:0] blank_n;

    int total = 0;
    int bad   = 0;
    int mode_pulses = 0;
    int loads = 0;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_CYCLES   (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_mode(btn_mode),
        .btn_up  (btn_up),
        .cur_bcd0(cur_bcd0),
        .cur_bcd1(cur_bcd1),
        .cur_bcd2(cur_bcd2),
        .cur_bcd3(cur_bcd3),
        .set_bcd0(set_bcd0),
        .set_bcd1(set_bcd1),
        .set_bcd2(set_bcd2),
        .set_bcd3(set_bcd3),
        .load    (load),
        .run_en  (run_en),
        .blank_n (blank_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] set_time();
        return {set_bcd3, set_bcd2, set_bcd1, set_bcd0};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (dut.press_q[0]) mode_pulses++;
        end
    endtask

    task automatic set_cur(input logic [15:0] t);
        {cur_bcd3, cur_bcd2, cur_bcd1, cur_bcd0} = t;
    endtask

    task automatic press(input logic m, input logic u);
        btn_mode = m;
        btn_up   = u;
        tick(12);
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        tick(12);
    endtask

    initial begin
        rst_n    = 1'b0;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        set_cur(16'h0000);
        tick(3);
        check("rst_time",  32'(set_time()), 32'h1200);
        check("rst_load",  32'(load),       32'd0);
        check("rst_runen", 32'(run_en),     32'd1);
        check("rst_blank", 32'(blank_n),    32'hf);
        rst_n = 1'b1;
        tick(3);

        // bounce: 2-cycle pulses must not register, final rise gives one press
        set_cur(16'h1145);
        mode_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            btn_mode = 1'b1;
            tick(2);
            btn_mode = 1'b0;
            tick(2);
        end
        btn_mode = 1'b1;
        tick(6);
        check("bnc_pulse6", 32'(mode_pulses), 32'd0);
        tick(1);
        check("bnc_pulse7", 32'(mode_pulses), 32'd1);
        check("bnc_run7",   32'(run_en),      32'd1);
        tick(1);
        check("bnc_run8",   32'(run_en),      32'd0);
        check("bnc_time",   32'(set_time()),  32'h1145);
        check("bnc_blank0", 32'(blank_n),     32'hf);
        tick(7);
        check("blink_vis",  32'(blank_n),     32'hf);
        tick(1);
        check("blink_off",  32'(blank_n),     32'h3);
        btn_mode = 1'b0;
        tick(12);
        check("bnc_once",   32'(mode_pulses), 32'd1);

        // hour wrap 11 -> 12 -> 01
        press(1'b0, 1'b1);
        check("hr_12", 32'(set_time()), 32'h1245);
        press(1'b0, 1'b1);
        check("hr_01", 32'(set_time()), 32'h0145);
        check("hr_runen", 32'(run_en), 32'd0);

        // asynchronous reset mid-edit, no clock edge needed
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_time",  32'(set_time()), 32'h1200);
        check("arst_load",  32'(load),       32'd0);
        check("arst_runen", 32'(run_en),     32'd1);
        check("arst_blank", 32'(blank_n),    32'hf);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // minute wrap 58 -> 59 -> 00, hour untouched
        set_cur(16'h1258);
        press(1'b1, 1'b0);
        check("min_cap", 32'(set_time()), 32'h1258);
        press(1'b1, 1'b0);
        check("min_runen", 32'(run_en), 32'd0);
        press(1'b0, 1'b1);
        check("min_59", 32'(set_time()), 32'h1259);
        press(1'b0, 1'b1);
        check("min_00", 32'(set_time()), 32'h1200);
        press(1'b1, 1'b0);
        check("min_back_run", 32'(run_en), 32'd1);

        // simultaneous presses in SET_HR, then commit at 03:27
        set_cur(16'h0226);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("sim_hr03", 32'(set_time()), 32'h0326);
        press(1'b1, 1'b1);
        check("sim_time",  32'(set_time()), 32'h0326);
        check("sim_runen", 32'(run_en),     32'd0);
        press(1'b0, 1'b1);
        check("sim_min27", 32'(set_time()), 32'h0327);
        loads = 0;
        btn_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (load) begin
                loads++;
                check("cmt_time",  32'(set_time()), 32'h0327);
                check("cmt_runen", 32'(run_en),     32'd1);
                check("cmt_blank", 32'(blank_n),    32'hf);
            end
        end
        btn_mode = 1'b0;
        tick(12);
        check("cmt_loads", 32'(loads),       32'd1);
        check("cmt_hold",  32'(set_time()),  32'h0327);

        // up in RUN is ignored
        press(1'b0, 1'b1);
        check("run_up_time",  32'(set_time()), 32'h0327);
        check("run_up_runen", 32'(run_en),     32'd1);

        // invalid capture 13:60 falls back to 12:00
        set_cur(16'h1360);
        press(1'b1, 1'b0);
        check("inv_time",  32'(set_time()), 32'h1200);
        check("inv_runen", 32'(run_en),     32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
